imem_loader: RTL and testbench

- Host-side initiator for the core's software control interface: drives sw_reset, sw_mem_addr, sw_mem_wdata and sw_mem_cmd, and consumes hw_mem_rdata.
- Accepts a valid/ready stream of instruction words, holds the core in reset, and writes the words into instruction memory at consecutive word addresses.
- Optionally reads the image back and checks it against a running checksum, then releases the core to run.
- Sits between the host register/DMA path and the pipelined core's control ports.

---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// ============================================================================
// imem_loader_if : instruction stream and core software-control bus
// Revision 1.0
// ============================================================================
`default_nettype none

interface imem_loader_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [31:0] sw_reset;
  logic [31:0] sw_mem_addr;
  logic [31:0] sw_mem_wdata;
  logic [31:0] sw_mem_cmd;
  logic [31:0] hw_mem_rdata;

  // master: the loader (stream sink, core-control driver)
  modport master (
    input  s_valid, s_data, hw_mem_rdata,
    output s_ready, sw_reset, sw_mem_addr, sw_mem_wdata, sw_mem_cmd
  );

  // slave: host stream source plus the core's control ports
  modport slave (
    output s_valid, s_data, hw_mem_rdata,
    input  s_ready, sw_reset, sw_mem_addr, sw_mem_wdata, sw_mem_cmd
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : holds the core in reset, streams words into IMEM, optionally
//               reads them back against a checksum, then releases the core.
// Revision 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_W    = 11,
  parameter int CNT_W     = 10,
  parameter int MAX_WORDS = 512,
  parameter int HOLD_CYC  = 4,
  parameter int RD_LAT    = 2,
  parameter int VERIFY    = 1
) (
  input  wire logic              clk,
  input  wire logic              rstb,
  input  wire logic              start,
  input  wire logic              abort,
  input  wire logic              auto_run,
  input  wire logic [ADDR_W-1:0] base_addr,
  input  wire logic [CNT_W-1:0]  num_words,
  imem_loader_if.master          bus,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             error,
  output logic [31:0]            err_sum
);

  localparam int LW = ADDR_W + CNT_W + 3;
  localparam int HW = $clog2(HOLD_CYC + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    WRITE  = 3'd2,
    READ   = 3'd3,
    CHECK  = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [CNT_W-1:0]  count_q, acc_q, issue_q, cap_q;
  logic [HW-1:0]     hold_q;
  logic [31:0]       wsum_q, rsum_q, wdata_q;
  logic [RD_LAT:0]   vpipe_q;
  logic              run_q, cmd_q, sw_reset_q;

  logic [LW-1:0]     end_addr;
  logic              len_bad, in_busy, ready, accept, issue, capture, last_cap;

  assign end_addr = LW'(base_addr) + (LW'(num_words) << 2);
  assign len_bad  = (num_words == '0)
                 || ({1'b0, num_words} > (CNT_W+1)'(MAX_WORDS))
                 || (base_addr[1:0] != 2'b00)
                 || (end_addr > (LW'(1) << ADDR_W));

  always_comb begin
    state_nx = state;
    in_busy  = (state == HOLD) || (state == WRITE) || (state == READ) || (state == CHECK);
    ready    = (state == WRITE) && (acc_q < count_q);
    accept   = ready && bus.s_valid && !abort;
    issue    = (state == READ) && (issue_q < count_q) && !abort;
    capture  = (state == READ) && vpipe_q[RD_LAT];
    last_cap = capture && (cap_q == count_q - CNT_W'(1));
    case (state)
      IDLE:    if (start) state_nx = len_bad ? FINISH : HOLD;
      HOLD:    if (hold_q == HW'(HOLD_CYC - 1)) state_nx = WRITE;
      WRITE:   if (acc_q == count_q) state_nx = (VERIFY != 0) ? READ : FINISH;
      READ:    if (last_cap) state_nx = CHECK;
      CHECK:   state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (in_busy && abort) state_nx = FINISH;
  end

  always_ff @(posedge clk) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      base_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      acc_q      <= '0;
      issue_q    <= '0;
      cap_q      <= '0;
      hold_q     <= '0;
      wsum_q     <= '0;
      rsum_q     <= '0;
      wdata_q    <= '0;
      vpipe_q    <= '0;
      run_q      <= 1'b0;
      cmd_q      <= 1'b0;
      sw_reset_q <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 2'd0;
      err_sum    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sw_reset_q <= 1'b1;
          if (len_bad) begin
            error <= 2'd3;
          end else begin
            base_q  <= base_addr;
            count_q <= num_words;
            run_q   <= auto_run;
            busy    <= 1'b1;
            error   <= 2'd0;
            wsum_q  <= '0;
            rsum_q  <= '0;
            acc_q   <= '0;
            issue_q <= '0;
            cap_q   <= '0;
            hold_q  <= '0;
            vpipe_q <= '0;
          end
        end
        HOLD: hold_q <= hold_q + HW'(1);
        WRITE: begin
          cmd_q <= accept;
          if (accept) begin
            addr_q  <= base_q + ADDR_W'({acc_q, 2'b00});
            wdata_q <= bus.s_data;
            wsum_q  <= wsum_q + bus.s_data;
            acc_q   <= acc_q + CNT_W'(1);
          end
        end
        READ: begin
          // vpipe_q[k] marks that the address presented k cycles ago is in flight
          vpipe_q <= (RD_LAT+1)'({vpipe_q, issue});
          if (issue) begin
            addr_q  <= base_q + ADDR_W'({issue_q, 2'b00});
            issue_q <= issue_q + CNT_W'(1);
          end
          if (capture) begin
            rsum_q <= rsum_q + bus.hw_mem_rdata;
            cap_q  <= cap_q + CNT_W'(1);
          end
        end
        CHECK: if (wsum_q != rsum_q) begin
          error   <= 2'd1;
          err_sum <= rsum_q;
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          cmd_q <= 1'b0;
          if ((error == 2'd0) && run_q) sw_reset_q <= 1'b0;
        end
        default: ;
      endcase
      // abort overrides any same-cycle write or readback bookkeeping
      if (in_busy && abort) begin
        cmd_q      <= 1'b0;
        error      <= 2'd2;
        sw_reset_q <= 1'b1;
      end
    end
  end

  assign bus.s_ready      = ready;
  assign bus.sw_reset     = {31'd0, sw_reset_q};
  assign bus.sw_mem_addr  = {{(32-ADDR_W){1'b0}}, addr_q};
  assign bus.sw_mem_wdata = wdata_q;
  assign bus.sw_mem_cmd   = {31'd0, cmd_q};

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes, done
// results and state probes; a negedge monitor pops and compares them.
`default_nettype none

module tb_imem_loader;

  typedef struct { logic [31:0] addr; logic [31:0] data; int gap; } wr_t;
  typedef struct { logic [1:0] err; logic [31:0] sum; logic chk_sum; logic [31:0] swr; int max_lat; } dn_t;
  typedef struct {
    logic [31:0] swr; logic [31:0] cmd; logic rdy; logic bsy; logic dn; logic [1:0] err;
    logic full; logic [31:0] addr; logic [31:0] sum;
  } pr_t;

  logic        clk = 1'b0;
  logic        rstb, start, abort, auto_run;
  logic [10:0] base_addr;
  logic [9:0]  num_words;
  logic        busy, done;
  logic [1:0]  error;
  logic [31:0] err_sum;
  logic        corrupt, end_req, end_done;
  logic [31:0] mem [0:511];
  logic [31:0] rd1, rd2;

  wr_t wq[$];
  dn_t dq[$];
  pr_t pq[$];
  int  checks = 0, errors = 0, cyc = 0, start_cyc = 0, last_wr = 0;

  imem_loader_if bus_if();

  imem_loader dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort), .auto_run(auto_run),
    .base_addr(base_addr), .num_words(num_words), .bus(bus_if),
    .busy(busy), .done(done), .error(error), .err_sum(err_sum)
  );

  always #5 clk = ~clk;

  // IMEM model with a two-cycle read pipeline; optional corruption of word 1
  always @(posedge clk) begin
    if (bus_if.sw_mem_cmd == 32'd1) mem[bus_if.sw_mem_addr[10:2]] <= bus_if.sw_mem_wdata;
    rd1 <= mem[bus_if.sw_mem_addr[10:2]]
         + ((corrupt && bus_if.sw_mem_addr[10:0] == 11'h004) ? 32'd1 : 32'd0);
    rd2 <= rd1;
  end
  assign bus_if.hw_mem_rdata = rd2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    wr_t w; dn_t d; pr_t p;
    forever begin
      @(negedge clk);
      cyc++;
      if (start === 1'b1) start_cyc = cyc;
      if (bus_if.sw_mem_cmd !== 32'd0 && bus_if.sw_mem_cmd !== 32'bx) begin
        if (wq.size() == 0) chk("unexpected_write", bus_if.sw_mem_cmd, 32'd0);
        else begin
          w = wq.pop_front();
          chk("wr_cmd", bus_if.sw_mem_cmd, 32'd1);
          chk("wr_addr", bus_if.sw_mem_addr, w.addr);
          chk("wr_data", bus_if.sw_mem_wdata, w.data);
          if (w.gap != 0) chk("wr_gap", cyc - last_wr, w.gap);
          last_wr = cyc;
        end
      end
      if (done === 1'b1) begin
        if (dq.size() == 0) chk("unexpected_done", {31'd0, done}, 32'd0);
        else begin
          d = dq.pop_front();
          chk("done_error", {30'd0, error}, {30'd0, d.err});
          chk("done_sw_reset", bus_if.sw_reset, d.swr);
          chk("done_busy", {31'd0, busy}, 32'd0);
          if (d.chk_sum) chk("done_err_sum", err_sum, d.sum);
          if (d.max_lat != 0) chk("done_latency_ok", {31'd0, (cyc - start_cyc) <= d.max_lat}, 32'd1);
        end
      end
      if (pq.size() > 0) begin
        p = pq.pop_front();
        chk("probe_sw_reset", bus_if.sw_reset, p.swr);
        chk("probe_cmd", bus_if.sw_mem_cmd, p.cmd);
        chk("probe_s_ready", {31'd0, bus_if.s_ready}, {31'd0, p.rdy});
        chk("probe_busy", {31'd0, busy}, {31'd0, p.bsy});
        chk("probe_done", {31'd0, done}, {31'd0, p.dn});
        chk("probe_error", {30'd0, error}, {30'd0, p.err});
        if (p.full) begin
          chk("probe_addr", bus_if.sw_mem_addr, p.addr);
          chk("probe_err_sum", err_sum, p.sum);
        end
      end
      if (end_req && !end_done) begin
        chk("leftover_writes", wq.size(), 32'd0);
        chk("leftover_dones", dq.size(), 32'd0);
        end_done = 1'b1;
      end
    end
  end

  task automatic push_wr(input logic [31:0] a, input logic [31:0] dat, input int gap);
    wr_t w; w.addr = a; w.data = dat; w.gap = gap; wq.push_back(w);
  endtask

  task automatic push_done(input logic [1:0] e, input logic [31:0] s, input logic cs,
                           input logic [31:0] swr, input int lat);
    dn_t d; d.err = e; d.sum = s; d.chk_sum = cs; d.swr = swr; d.max_lat = lat; dq.push_back(d);
  endtask

  task automatic push_probe(input logic [31:0] swr, input logic rdy, input logic bsy,
                            input logic [1:0] e, input logic full);
    pr_t p;
    p.swr = swr; p.cmd = 32'd0; p.rdy = rdy; p.bsy = bsy; p.dn = 1'b0; p.err = e;
    p.full = full; p.addr = 32'd0; p.sum = 32'd0;
    pq.push_back(p);
  endtask

  task automatic do_start(input logic [10:0] b, input logic [9:0] n, input logic ar);
    base_addr = b; num_words = n; auto_run = ar; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] dat);
    logic got;
    got = 1'b0;
    s_drive(1'b1, dat);
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (bus_if.s_ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      $display("FAIL send_timeout actual=no_ready required=ready");
      $fatal(1);
    end
    @(posedge clk); #1;
    s_drive(1'b0, 32'd0);
  endtask

  task automatic s_drive(input logic v, input logic [31:0] dat);
    bus_if.s_valid = v; bus_if.s_data = dat;
  endtask

  task automatic wait_done;
    logic got;
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    if (!got) begin
      $display("FAIL wait_done_timeout actual=no_done required=done");
      $fatal(1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rstb = 1'b0; start = 1'b0; abort = 1'b0; auto_run = 1'b0;
    base_addr = '0; num_words = '0; corrupt = 1'b0;
    end_req = 1'b0; end_done = 1'b0;
    s_drive(1'b0, 32'd0);
    repeat (2) @(posedge clk); #1;
    push_probe(32'd1, 1'b0, 1'b0, 2'd0, 1'b1);
    @(posedge clk); #1;
    rstb = 1'b1;
    @(posedge clk); #1;

    // back-to-back load, verified, core released
    push_wr(32'h0, 32'hE3A01005, 0);
    push_wr(32'h4, 32'hE2811001, 1);
    push_wr(32'h8, 32'hEAFFFFFE, 1);
    push_done(2'd0, 32'd0, 1'b1, 32'd0, 0);
    do_start(11'h0, 10'd3, 1'b1);
    push_probe(32'd1, 1'b0, 1'b1, 2'd0, 1'b0);
    send(32'hE3A01005); send(32'hE2811001); send(32'hEAFFFFFE);
    wait_done;

    // same load with a bubble between words; start re-asserts sw_reset
    push_wr(32'h0, 32'hE3A01005, 0);
    push_wr(32'h4, 32'hE2811001, 2);
    push_wr(32'h8, 32'hEAFFFFFE, 2);
    push_done(2'd0, 32'd0, 1'b1, 32'd0, 0);
    do_start(11'h0, 10'd3, 1'b1);
    push_probe(32'd1, 1'b0, 1'b1, 2'd0, 1'b0);
    send(32'hE3A01005); @(posedge clk); #1;
    send(32'hE2811001); @(posedge clk); #1;
    send(32'hEAFFFFFE);
    wait_done;

    // readback of word 1 off by one: write sum 0xB1212004, read sum 0xB1212005
    corrupt = 1'b1;
    push_wr(32'h0, 32'hE3A01005, 0);
    push_wr(32'h4, 32'hE2811001, 1);
    push_wr(32'h8, 32'hEAFFFFFE, 1);
    push_done(2'd1, 32'hB1212005, 1'b1, 32'd1, 0);
    do_start(11'h0, 10'd3, 1'b1);
    send(32'hE3A01005); send(32'hE2811001); send(32'hEAFFFFFE);
    wait_done;
    corrupt = 1'b0;

    // bad length / overrun: no writes, fast done
    push_done(2'd3, 32'd0, 1'b0, 32'd1, 2);
    do_start(11'h0, 10'd0, 1'b1);
    wait_done;
    push_done(2'd3, 32'd0, 1'b0, 32'd1, 2);
    do_start(11'h7FC, 10'd2, 1'b1);
    wait_done;

    // load ending exactly at the top of IMEM is legal; auto_run off keeps core held
    push_wr(32'h7F8, 32'hA5A5A5A5, 0);
    push_wr(32'h7FC, 32'h5A5A5A5A, 1);
    push_done(2'd0, 32'd0, 1'b0, 32'd1, 0);
    do_start(11'h7F8, 10'd2, 1'b0);
    send(32'hA5A5A5A5); send(32'h5A5A5A5A);
    wait_done;

    // abort alongside the second accepted word
    push_wr(32'h20, 32'h11111111, 0);
    push_done(2'd2, 32'd0, 1'b0, 32'd1, 0);
    do_start(11'h20, 10'd4, 1'b1);
    send(32'h11111111);
    s_drive(1'b1, 32'h22222222); abort = 1'b1;
    @(posedge clk); #1;
    s_drive(1'b0, 32'd0); abort = 1'b0;
    push_probe(32'd1, 1'b0, 1'b1, 2'd2, 1'b0);
    wait_done;

    // reset in the middle of readback, then a clean reload
    push_wr(32'h40, 32'hDEADBEEF, 0);
    push_wr(32'h44, 32'h01234567, 1);
    push_wr(32'h48, 32'h89ABCDEF, 1);
    do_start(11'h40, 10'd3, 1'b1);
    send(32'hDEADBEEF); send(32'h01234567); send(32'h89ABCDEF);
    repeat (2) @(posedge clk); #1;
    rstb = 1'b0;
    @(posedge clk); #1;
    push_probe(32'd1, 1'b0, 1'b0, 2'd0, 1'b1);
    rstb = 1'b1;
    @(posedge clk); #1;
    push_wr(32'h40, 32'hCAFEF00D, 0);
    push_wr(32'h44, 32'h0BADF00D, 1);
    push_done(2'd0, 32'd0, 1'b1, 32'd0, 0);
    do_start(11'h40, 10'd2, 1'b1);
    send(32'hCAFEF00D); send(32'h0BADF00D);
    wait_done;

    repeat (3) @(posedge clk); #1;
    end_req = 1'b1;
    for (int t = 0; t < 10 && !end_done; t++) @(posedge clk);
    if (!end_done) begin
      $display("FAIL end_handshake actual=pending required=done");
      $fatal(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
